alias_reduction: RTL and testbench

- Streaming MP3 alias-reduction stage; sits directly downstream of the stereo-processing stage.
- Consumes per-granule ch1/ch2 sample streams in frequency order, 576 samples per channel per granule, signed Q2.14.
- Applies the 8 anti-alias butterflies at each subband boundary and emits samples in the same order, 16 samples late.
- Feeds the IMDCT stage.

---
 rtl/alias_pkg.sv | 27 ++
 rtl/alias_butterfly.sv | 41 ++++
 rtl/alias_reduction.sv | 176 +++++++++++++++++
 tb/tb_alias_reduction.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alias_pkg.sv
// Shared constants, anti-alias coefficient tables and FSM state type for the alias-reduction stage.
package alias_pkg;

  localparam int unsigned NUM_SAMPLES = 576;
  localparam int unsigned SB_SIZE     = 18;
  localparam int unsigned DELAY       = 16;
  localparam int unsigned DW          = 16;
  localparam int unsigned NUM_BFLY    = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  // Q2.14 anti-alias coefficients cs[i] = 1/sqrt(1+c^2), ca[i] = c/sqrt(1+c^2)
  localparam logic signed [DW-1:0] CS_TAB [NUM_BFLY] = '{
    16'sh36E1, 16'sh386E, 16'sh3CC7, 16'sh3EEF,
    16'sh3FB7, 16'sh3FF2, 16'sh3FFE, 16'sh4000
  };

  localparam logic signed [DW-1:0] CA_TAB [NUM_BFLY] = '{
    16'shDF13, 16'shE1CF, 16'shEBF2, 16'shF45C,
    16'shF9F2, 16'shFD61, 16'shFF17, 16'shFFC3
  };

endpackage

// File: rtl/alias_butterfly.sv
// Combinational anti-alias butterfly on one lo/hi pair, Q2.14 in and out.
// ALIAS_SAT_EN: saturate results that leave the Q2.14 range instead of wrapping.
module alias_butterfly
  import alias_pkg::*;
(
  input  logic signed [DW-1:0] lo_i,
  input  logic signed [DW-1:0] hi_i,
  input  logic signed [DW-1:0] cs_i,
  input  logic signed [DW-1:0] ca_i,
  output logic signed [DW-1:0] lo_o,
  output logic signed [DW-1:0] hi_o
);

  localparam int unsigned PW = 2 * DW;
  localparam int unsigned SW = PW + 1;

  logic signed [PW-1:0] lo_cs, hi_ca, hi_cs, lo_ca;
  logic signed [SW-1:0] lo_sum, hi_sum;

  // Take bits [29:14] of the 33-bit sum, optionally clamping on overflow
  function automatic logic signed [DW-1:0] to_q14(input logic signed [SW-1:0] s);
`ifdef ALIAS_SAT_EN
    if (s[SW-1:SW-4] != {4{s[SW-1]}}) begin
      return s[SW-1] ? 16'sh8000 : 16'sh7FFF;
    end
`endif
    return DW'(s >>> 14);
  endfunction

  assign lo_cs  = PW'(lo_i) * PW'(cs_i);
  assign hi_ca  = PW'(hi_i) * PW'(ca_i);
  assign hi_cs  = PW'(hi_i) * PW'(cs_i);
  assign lo_ca  = PW'(lo_i) * PW'(ca_i);

  assign lo_sum = SW'(lo_cs) - SW'(hi_ca);
  assign hi_sum = SW'(hi_cs) + SW'(lo_ca);

  assign lo_o   = to_q14(lo_sum);
  assign hi_o   = to_q14(hi_sum);

endmodule

// File: rtl/alias_reduction.sv
// Streaming MP3 alias-reduction stage: 16-deep reorder ring, butterflies applied on accept.
// Optional build macro ALIAS_SAT_EN selects saturating butterfly arithmetic.
module alias_reduction
  import alias_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          window_switching_flag_in,
  input  logic [1:0]    block_type_in,
  input  logic          mixed_block_flag_in,
  input  logic          gr_in,
  input  logic [DW-1:0] ch1_in,
  input  logic [DW-1:0] ch2_in,
  input  logic          din_v,
  output logic          din_ready,
  output logic [DW-1:0] ch1_out,
  output logic [DW-1:0] ch2_out,
  output logic [9:0]    idx_out,
  output logic          gr_out,
  output logic          dout_v
);

  localparam int unsigned CW = 10;
  localparam int unsigned PW = 5;
  localparam int unsigned BW = 5;
  localparam int unsigned RW = 4;

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [PW-1:0]        pos_q, pos_d;
  logic [BW-1:0]        sb_q, sb_d;
  logic                 wsf_q, mixed_q, gr_q;
  logic [1:0]           bt_q;
  logic                 din_ready_q, din_ready_d;
  logic                 dout_v_q, gr_out_q;
  logic [DW-1:0]        ch1_out_q, ch2_out_q;
  logic [CW-1:0]        idx_out_q;
  logic signed [DW-1:0] ring1_q [DELAY];
  logic signed [DW-1:0] ring2_q [DELAY];

  logic                 accept_c, emit_c, latch_c, bf_en_c, short_c, sb_ok_c;
  logic [RW-1:0]        wr_idx_c, lo_idx_c;
  logic signed [DW-1:0] lo1_new, hi1_new, lo2_new, hi2_new;

  // Next-state, counters and per-cycle strobes
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    pos_d    = pos_q;
    sb_d     = sb_q;
    accept_c = 1'b0;
    emit_c   = 1'b0;
    latch_c  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (din_v) begin
          accept_c = 1'b1;
          latch_c  = 1'b1;
          state_d  = RUN;
        end
      end
      RUN: begin
        if (din_v) begin
          accept_c = 1'b1;
          if (cnt_q == CW'(NUM_SAMPLES - 1)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        emit_c = 1'b1;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == CW'(NUM_SAMPLES + DELAY - 1)) begin
          state_d = IDLE;
          cnt_d   = '0;
          pos_d   = '0;
          sb_d    = '0;
        end
      end
      default: state_d = IDLE;
    endcase
    if (accept_c) begin
      cnt_d  = cnt_q + CW'(1);
      emit_c = (cnt_q >= CW'(DELAY));
      if (pos_q == PW'(SB_SIZE - 1)) begin
        pos_d = '0;
        sb_d  = sb_q + BW'(1);
      end else begin
        pos_d = pos_q + PW'(1);
      end
    end
    din_ready_d = (state_d != DRAIN);
  end

  // Butterfly gating from latched side info; short-only blocks pass through
  assign short_c  = wsf_q && (bt_q == 2'd2);
  assign sb_ok_c  = !short_c || (mixed_q && (sb_q == BW'(1)));
  assign bf_en_c  = accept_c && (pos_q < PW'(NUM_BFLY)) && (sb_q != '0) && sb_ok_c;
  assign wr_idx_c = cnt_q[RW-1:0];
  assign lo_idx_c = RW'(cnt_q[RW-1:0] - RW'(1) - RW'({pos_q[2:0], 1'b0}));

  alias_butterfly u_bfly_ch1 (
    .lo_i (ring1_q[lo_idx_c]),
    .hi_i (ch1_in),
    .cs_i (CS_TAB[pos_q[2:0]]),
    .ca_i (CA_TAB[pos_q[2:0]]),
    .lo_o (lo1_new),
    .hi_o (hi1_new)
  );

  alias_butterfly u_bfly_ch2 (
    .lo_i (ring2_q[lo_idx_c]),
    .hi_i (ch2_in),
    .cs_i (CS_TAB[pos_q[2:0]]),
    .ca_i (CA_TAB[pos_q[2:0]]),
    .lo_o (lo2_new),
    .hi_o (hi2_new)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      pos_q       <= '0;
      sb_q        <= '0;
      wsf_q       <= 1'b0;
      bt_q        <= '0;
      mixed_q     <= 1'b0;
      gr_q        <= 1'b0;
      din_ready_q <= 1'b1;
      dout_v_q    <= 1'b0;
      ch1_out_q   <= '0;
      ch2_out_q   <= '0;
      idx_out_q   <= '0;
      gr_out_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pos_q       <= pos_d;
      sb_q        <= sb_d;
      din_ready_q <= din_ready_d;
      dout_v_q    <= emit_c;
      if (latch_c) begin
        wsf_q   <= window_switching_flag_in;
        bt_q    <= block_type_in;
        mixed_q <= mixed_block_flag_in;
        gr_q    <= gr_in;
      end
      // Slot being overwritten holds sample cnt-16, now final
      if (emit_c) begin
        ch1_out_q <= ring1_q[wr_idx_c];
        ch2_out_q <= ring2_q[wr_idx_c];
        idx_out_q <= CW'(cnt_q - CW'(DELAY));
        gr_out_q  <= gr_q;
      end
    end
  end

  // Ring storage carries no reset
  always_ff @(posedge clk) begin
    if (rst && accept_c) begin
      ring1_q[wr_idx_c] <= bf_en_c ? hi1_new : ch1_in;
      ring2_q[wr_idx_c] <= bf_en_c ? hi2_new : ch2_in;
    end
    if (rst && bf_en_c) begin
      ring1_q[lo_idx_c] <= lo1_new;
      ring2_q[lo_idx_c] <= lo2_new;
    end
  end

  assign din_ready = din_ready_q;
  assign dout_v    = dout_v_q;
  assign ch1_out   = ch1_out_q;
  assign ch2_out   = ch2_out_q;
  assign idx_out   = idx_out_q;
  assign gr_out    = gr_out_q;

endmodule

// File: tb/tb_alias_reduction.sv
// Scoreboard bench for alias_reduction: per-granule reference model feeds an expected queue,
// a negedge monitor pops and compares every dout_v beat.
module tb_alias_reduction;

  localparam int N  = 576;
  localparam int CS [8] = '{14049, 14446, 15559, 16111, 16311, 16370, 16382, 16384};
  localparam int CA [8] = '{-8429, -7729, -5134, -2980, -1550, -671, -233, -61};

  typedef struct packed {
    logic [9:0]  idx;
    logic [15:0] c1;
    logic [15:0] c2;
    logic        gr;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        window_switching_flag_in, mixed_block_flag_in, gr_in, din_v;
  logic [1:0]  block_type_in;
  logic [15:0] ch1_in, ch2_in;
  logic        din_ready, gr_out, dout_v;
  logic [15:0] ch1_out, ch2_out;
  logic [9:0]  idx_out;

  exp_t        exp_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  shortint     x1[N], x2[N], y1[N], y2[N];
  logic [15:0] got1[N], got2[N];
  logic        wsf, mixed, gr;
  logic [1:0]  bt;

  always #5 clk = ~clk;

  alias_reduction dut (
    .clk                      (clk),
    .rst                      (rst),
    .window_switching_flag_in (window_switching_flag_in),
    .block_type_in            (block_type_in),
    .mixed_block_flag_in      (mixed_block_flag_in),
    .gr_in                    (gr_in),
    .ch1_in                   (ch1_in),
    .ch2_in                   (ch2_in),
    .din_v                    (din_v),
    .din_ready                (din_ready),
    .ch1_out                  (ch1_out),
    .ch2_out                  (ch2_out),
    .idx_out                  (idx_out),
    .gr_out                   (gr_out),
    .dout_v                   (dout_v)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Product sum -> Q2.14 with truncation (wrap or clamp)
  function automatic shortint q14(input longint s);
    longint t;
`ifdef ALIAS_SAT_EN
    if (s > 64'sd536870911) return 16'sh7FFF;
    if (s < -64'sd536870912) return 16'sh8000;
`endif
    t = s >>> 14;
    return shortint'(t[15:0]);
  endfunction

  // Reference: butterfly the whole granule in the frequency domain, then queue all outputs
  task automatic build_model();
    longint lo, hi;
    int a, b;
    exp_t e;
    for (int k = 0; k < N; k++) begin
      y1[k] = x1[k];
      y2[k] = x2[k];
      got1[k] = 'x;
      got2[k] = 'x;
    end
    for (int sb = 1; sb < 32; sb++) begin
      if (wsf && bt == 2'd2 && (!mixed || sb != 1)) continue;
      for (int i = 0; i < 8; i++) begin
        a = 18 * sb - 1 - i;
        b = 18 * sb + i;
        lo = y1[a]; hi = y1[b];
        y1[a] = q14(lo * CS[i] - hi * CA[i]);
        y1[b] = q14(hi * CS[i] + lo * CA[i]);
        lo = y2[a]; hi = y2[b];
        y2[a] = q14(lo * CS[i] - hi * CA[i]);
        y2[b] = q14(hi * CS[i] + lo * CA[i]);
      end
    end
    for (int k = 0; k < N; k++) begin
      e.idx = 10'(k);
      e.c1  = 16'(y1[k]);
      e.c2  = 16'(y2[k]);
      e.gr  = gr;
      exp_q.push_back(e);
    end
  endtask

  // Monitor: every output beat must match the head of the expected queue
  always @(negedge clk) begin
    exp_t e;
    if (dout_v === 1'b1) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_output: got idx %0d with empty expected queue", idx_out);
      end else begin
        e = exp_q.pop_front();
        if ({idx_out, ch1_out, ch2_out, gr_out} !== e) begin
          n_fail++;
          $display("FAIL out_beat: got idx=%0d ch1=%h ch2=%h gr=%b expected idx=%0d ch1=%h ch2=%h gr=%b",
                   idx_out, ch1_out, ch2_out, gr_out, e.idx, e.c1, e.c2, e.gr);
        end
      end
      if (idx_out < 10'(N)) begin
        got1[idx_out] = ch1_out;
        got2[idx_out] = ch2_out;
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (din_ready !== 1'b1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (din_ready !== 1'b1) chk("wait_ready_timeout", 32'(din_ready), 32'd1);
  endtask

  // Side info is valid only with sample 0; later samples carry junk side info
  task automatic drive_granule(input bit gaps, input int count);
    for (int k = 0; k < count; k++) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        din_v = 1'b0;
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
      din_v   = 1'b1;
      ch1_in  = 16'(x1[k]);
      ch2_in  = 16'(x2[k]);
      if (k == 0) begin
        window_switching_flag_in = wsf;
        block_type_in            = bt;
        mixed_block_flag_in      = mixed;
        gr_in                    = gr;
      end else begin
        window_switching_flag_in = 1'($urandom);
        block_type_in            = 2'($urandom);
        mixed_block_flag_in      = 1'($urandom);
        gr_in                    = 1'($urandom);
      end
      @(posedge clk); #1;
      if (!gaps && k == 15) chk("no_dout_before_16", 32'(dout_v), 32'd0);
      if (!gaps && k == 16) chk("first_dout_idx0", {21'd0, dout_v, idx_out}, {21'd0, 1'b1, 10'd0});
    end
    din_v = 1'b0;
  endtask

  task automatic finish_granule();
    int low = 0;
    int dv_miss = 0;
    while (din_ready !== 1'b1 && low < 40) begin
      if (dout_v !== 1'b1) dv_miss++;
      low++;
      @(posedge clk); #1;
    end
    chk("ready_low_cycles", 32'(low), 32'd16);
    chk("drain_dout_continuous", 32'(dv_miss), 32'd0);
    @(negedge clk); #1;
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic run_granule(input bit gaps);
    wait_ready();
    build_model();
    drive_granule(gaps, N);
    finish_granule();
  endtask

  task automatic clear_x();
    for (int k = 0; k < N; k++) begin
      x1[k] = 16'sh0000;
      x2[k] = 16'sh0000;
    end
  endtask

  task automatic random_x(input int amp_bits);
    for (int k = 0; k < N; k++) begin
      x1[k] = shortint'(int'($urandom) >>> (32 - amp_bits));
      x2[k] = shortint'(int'($urandom) >>> (32 - amp_bits));
    end
  endtask

  task automatic random_side();
    wsf   = 1'($urandom);
    bt    = ($urandom_range(0, 1) == 1) ? 2'd2 : 2'($urandom);
    mixed = 1'($urandom);
    gr    = 1'($urandom);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int nz;
    rst = 1'b0;
    din_v = 1'b0;
    ch1_in = '0; ch2_in = '0;
    window_switching_flag_in = 1'b0; block_type_in = '0;
    mixed_block_flag_in = 1'b0; gr_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_din_ready", 32'(din_ready), 32'd1);
    chk("reset_dout_v", 32'(dout_v), 32'd0);
    chk("reset_idx_out", 32'(idx_out), 32'd0);
    chk("reset_ch_out", {ch1_out, ch2_out}, 32'd0);
    chk("reset_gr_out", 32'(gr_out), 32'd0);
    rst = 1'b1;

    // Long block impulse at x[17]
    clear_x();
    x1[17] = 16'sh4000; x2[17] = 16'sh4000;
    wsf = 1'b0; bt = 2'd0; mixed = 1'b0; gr = 1'b0;
    run_granule(1'b0);
    chk("long_out17_ch1", 32'(got1[17]), 32'h36E1);
    chk("long_out18_ch1", 32'(got1[18]), 32'hDF13);
    chk("long_out17_ch2", 32'(got2[17]), 32'h36E1);
    chk("long_out18_ch2", 32'(got2[18]), 32'hDF13);
    nz = 0;
    for (int k = 0; k < N; k++)
      if (k != 17 && k != 18 && (got1[k] !== 16'h0 || got2[k] !== 16'h0)) nz++;
    chk("long_others_zero", 32'(nz), 32'd0);

    // Back-to-back granule tagged gr=1 with random long-block data
    random_x(14);
    gr = 1'b1;
    run_granule(1'b0);
    chk("gr_out_tag1", 32'(gr_out), 32'd1);

    // Pure short blocks: pass-through
    clear_x();
    x1[17] = 16'sh4000; x2[17] = 16'sh4000;
    wsf = 1'b1; bt = 2'd2; mixed = 1'b0; gr = 1'b0;
    run_granule(1'b0);
    chk("short_out17", 32'(got1[17]), 32'h4000);
    chk("short_out18", 32'(got1[18]), 32'h0000);

    // Mixed block: only the sb 0/1 boundary is butterflied
    clear_x();
    x1[17] = 16'sh4000; x2[17] = 16'sh4000;
    x1[35] = 16'sh4000; x2[35] = 16'sh4000;
    mixed = 1'b1;
    run_granule(1'b0);
    chk("mixed_out17", 32'(got1[17]), 32'h36E1);
    chk("mixed_out18", 32'(got1[18]), 32'hDF13);
    chk("mixed_out35", 32'(got2[35]), 32'h4000);
    chk("mixed_out36", 32'(got2[36]), 32'h0000);

    // Overflow corner at the first boundary
    clear_x();
    x1[17] = 16'sh7FFF; x2[17] = 16'sh7FFF;
    x1[18] = 16'sh7FFF; x2[18] = 16'sh7FFF;
    wsf = 1'b0; bt = 2'd0; mixed = 1'b0;
    run_granule(1'b0);
`ifdef ALIAS_SAT_EN
    chk("overflow_out17", 32'(got1[17]), 32'h7FFF);
`else
    chk("overflow_out17", 32'(got1[17]), 32'hAF9A);
`endif

    // Reset in the middle of a gappy granule
    random_x(16);
    random_side();
    wait_ready();
    build_model();
    drive_granule(1'b1, 300);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("midreset_dout_v", 32'(dout_v), 32'd0);
    chk("midreset_din_ready", 32'(din_ready), 32'd1);
    exp_q.delete();
    rst = 1'b1;

    // Fresh granules after the reset, random side info, data and gaps
    for (int g = 0; g < 5; g++) begin
      random_x((g % 2 == 0) ? 14 : 16);
      random_side();
      run_granule(g != 2);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
